asg_word_gen: RTL and testbench
===============================

// Module: asg_word_gen
// PURPOSE
//  Parametrised alternating-step generator (ASG) producing OUT_W-bit random words over a valid/ready stream.
//  Three Galois LFSRs: R2 is the clock controller; R0 and R1 are stepped alternately; output bit = R0[0]^R1[0].
//  Adds runtime reseeding, zero-state protection, an enable and back-pressure to the single-bit generator.
//  Sits between the entropy source and the differential-privacy noise sampler.
// PARAMETERS
//  W0     28            width of R0
//  W1     29            width of R1
//  W2     30            width of R2 (controller)
//  MASK0  28'hff0000c   Galois feedback mask R0 (W0 bits)
//  MASK1  29'h1ffe0000  Galois feedback mask R1 (W1 bits)
//  MASK2  30'h3ff00011  Galois feedback mask R2 (W2 bits)
//  SEED0  28'ha85eacf   reset value R0, must be nonzero
//  SEED1  29'h1de46c20  reset value R1, must be nonzero
//  SEED2  30'h384c2686  reset value R2, must be nonzero
//  OUT_W  32            output word width, 2..64
// PORTS
//  clk        in   1      clock
//  rst        in   1      async reset, active high
//  gen_en     in   1      1 = generator may step
//  seed_wr    in   1      load seed_data into LFSR selected by seed_sel
//  seed_sel   in   2      0=R0, 1=R1, 2=R2, 3=ignored (no load, no error)
//  seed_data  in   30     seed; low Wn bits used for the selected Rn
//  seed_err   out  1      1-cycle pulse: rejected seed (zero in low Wn bits)
//  out_data   out  OUT_W  completed word; first generated bit in MSB
//  out_valid  out  1      out_data holds an unconsumed word
//  out_ready  in   1      consumer accepts word when out_valid&&out_ready
//  bit_cnt    out  log2(OUT_W)+1  bits accumulated into current partial word
// BEHAVIOUR
//  - Reset (async, any time, incl. mid-word): R0..R2=SEED0..2, accumulator=0, bit_cnt=0,
//    out_data=0, out_valid=0, seed_err=0. Partial word discarded.
//  - Galois step: Rn' = Rn[0] ? (Rn>>1)^MASKn : (Rn>>1).
//  - step = gen_en && !seed_wr && !(out_valid && !out_ready).
//  - On step, from current-cycle values: b = R0[0]^R1[0]; R2 always steps;
//    if R2[0]==1 R1 steps, R0 holds; else R0 steps, R1 holds. acc <= {acc[OUT_W-2:0], b}; bit_cnt++.
//  - States FILL (bit_cnt<OUT_W) / handoff: on the step where bit_cnt==OUT_W-1, out_data <= {acc[OUT_W-2:0],b},
//    out_valid<=1, bit_cnt<=0. Latency: first word valid OUT_W enabled steps after reset.
//  - out_valid&&out_ready with no word completing: out_valid<=0 next cycle. Handshake and completion in
//    same cycle: out_data replaced, out_valid stays 1 (no bubble, no loss).
//  - out_valid&&!out_ready: generator frozen (R0..R2, acc, bit_cnt hold); out_data stable until accepted.
//  - gen_en=0: everything holds; out_valid/out_data still drain via handshake.
//  - seed_wr, sel n, low Wn bits nonzero: Rn <= seed_data[Wn-1:0]; acc and bit_cnt cleared
//    (partial word dropped); a pending out_valid word is kept. No step that cycle.
//  - seed_wr with zero low bits: no register change, seed_err=1 next cycle for one cycle.
//  - Zero-state guard: if any Rn==0 (not reachable from nonzero seeds, checked anyway),
//    Rn <= SEEDn that cycle instead of stepping; acc/bit_cnt unaffected.
//  - Upper seed_data bits above Wn ignored.
// TESTING
//  1 Reset, gen_en=1, out_ready=1, OUT_W=8: out_valid first high exactly 8 cycles after rst deasserts;
//    1000 words match C golden model of the same ASG bit-for-bit.
//  2 out_ready=0 for 20 cycles after first word: out_data, R0..R2, bit_cnt unchanged; after ready=1,
//    following words equal golden stream with no gap or duplicate.
//  3 seed_wr sel=1 data=30'h0: seed_err one-cycle pulse, R1 unchanged; data=30'h1234 sel=1: R1=0x1234,
//    bit_cnt=0, next words match golden model reseeded with 0x1234.
//  4 rst asserted after 5 bits of a word: out_valid=0, bit_cnt=0, R0..R2=SEED*
//    asynchronously; stream restarts identical to test 1.
//  5 gen_en toggled 1/0 every cycle: word sequence equals test 1, at half rate.
//  6 force R0=0 via hierarchical deposit: next cycle R0=SEED0, no X on out_data.

Source files
------------

// File: rtl/asg_word_gen.sv
// Alternating-step generator: three Galois LFSRs shifted into OUT_W-bit words on a valid/ready stream.
// First word appears OUT_W enabled steps after reset; an unaccepted word freezes the generator until it is taken.
module asg_word_gen #(
    parameter int              W0    = 28,
    parameter int              W1    = 29,
    parameter int              W2    = 30,
    parameter logic [W0-1:0]   MASK0 = 28'hff0000c,
    parameter logic [W1-1:0]   MASK1 = 29'h1ffe0000,
    parameter logic [W2-1:0]   MASK2 = 30'h3ff00011,
    parameter logic [W0-1:0]   SEED0 = 28'ha85eacf,
    parameter logic [W1-1:0]   SEED1 = 29'h1de46c20,
    parameter logic [W2-1:0]   SEED2 = 30'h384c2686,
    parameter int              OUT_W = 32,
    localparam int             CNT_W = $clog2(OUT_W) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gen_en,
    input  logic             seed_wr,
    input  logic [1:0]       seed_sel,
    input  logic [29:0]      seed_data,
    output logic             seed_err,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] bit_cnt
);

    logic [W0-1:0]    r0, r0_nx;
    logic [W1-1:0]    r1, r1_nx;
    logic [W2-1:0]    r2, r2_nx;
    logic [OUT_W-2:0] acc;
    logic [OUT_W-1:0] word;
    logic             ld0, ld1, ld2, seed_zero;
    logic             step, fb, last;

    always_comb begin
        r0_nx = r0[0] ? ((r0 >> 1) ^ MASK0) : (r0 >> 1);
        r1_nx = r1[0] ? ((r1 >> 1) ^ MASK1) : (r1 >> 1);
        r2_nx = r2[0] ? ((r2 >> 1) ^ MASK2) : (r2 >> 1);

        ld0 = seed_wr && (seed_sel == 2'd0) && (seed_data[W0-1:0] != '0);
        ld1 = seed_wr && (seed_sel == 2'd1) && (seed_data[W1-1:0] != '0);
        ld2 = seed_wr && (seed_sel == 2'd2) && (seed_data[W2-1:0] != '0);
        seed_zero = seed_wr && (((seed_sel == 2'd0) && (seed_data[W0-1:0] == '0)) ||
                                ((seed_sel == 2'd1) && (seed_data[W1-1:0] == '0)) ||
                                ((seed_sel == 2'd2) && (seed_data[W2-1:0] == '0)));

        // A held word blocks generation so no bit is ever produced without a slot to land in.
        step = gen_en && !seed_wr && !(out_valid && !out_ready);
        fb   = r0[0] ^ r1[0];
        word = {acc, fb};
        last = (bit_cnt == CNT_W'(OUT_W - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r0        <= SEED0;
            r1        <= SEED1;
            r2        <= SEED2;
            acc       <= '0;
            bit_cnt   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            seed_err  <= 1'b0;
        end else begin
            seed_err <= seed_zero;

            // Seed load wins, then the all-zero recovery, then the normal alternating step.
            if (ld0)                  r0 <= seed_data[W0-1:0];
            else if (r0 == '0)        r0 <= SEED0;
            else if (step && !r2[0])  r0 <= r0_nx;

            if (ld1)                  r1 <= seed_data[W1-1:0];
            else if (r1 == '0)        r1 <= SEED1;
            else if (step && r2[0])   r1 <= r1_nx;

            if (ld2)                  r2 <= seed_data[W2-1:0];
            else if (r2 == '0)        r2 <= SEED2;
            else if (step)            r2 <= r2_nx;

            if (ld0 || ld1 || ld2) begin
                acc     <= '0;
                bit_cnt <= '0;
            end else if (step) begin
                acc     <= word[OUT_W-2:0];
                bit_cnt <= last ? '0 : bit_cnt + CNT_W'(1);
            end

            if (step && last) begin
                out_data  <= word;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_asg_word_gen.sv
// Bench for asg_word_gen at OUT_W=8: a behavioural ASG model feeds a word scoreboard,
// with a seed table and hand sequences for stall, async reset, enable toggling and zero-state recovery.
module tb_asg_word_gen;

    localparam int OUT_W = 8;
    localparam int CNT_W = $clog2(OUT_W) + 1;

    localparam logic [29:0] S0 = 30'h0a85eacf;
    localparam logic [29:0] S1 = 30'h1de46c20;
    localparam logic [29:0] S2 = 30'h384c2686;
    localparam logic [29:0] M0 = 30'h0ff0000c;
    localparam logic [29:0] M1 = 30'h1ffe0000;
    localparam logic [29:0] M2 = 30'h3ff00011;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             gen_en = 1'b0;
    logic             seed_wr = 1'b0;
    logic [1:0]       seed_sel = 2'd0;
    logic [29:0]      seed_data = '0;
    logic             out_ready = 1'b0;
    logic             seed_err;
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic [CNT_W-1:0] bit_cnt;

    asg_word_gen #(.OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .gen_en    (gen_en),
        .seed_wr   (seed_wr),
        .seed_sel  (seed_sel),
        .seed_data (seed_data),
        .seed_err  (seed_err),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bit_cnt   (bit_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic [29:0] data;
        logic        err;
        logic [29:0] r0;
        logic [29:0] r1;
        logic [29:0] r2;
    } seed_vec_t;

    int               n_vec = 0;
    int               n_err = 0;
    int               n_pop = 0;
    logic [29:0]      g0, g1, g2;
    logic [OUT_W-1:0] macc;
    int               mcnt;
    bit               mv, me;
    logic [OUT_W-1:0] exp_q[$];
    seed_vec_t        tbl[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [29:0] gal(input logic [29:0] x, input logic [29:0] m);
        return x[0] ? ((x >> 1) ^ m) : (x >> 1);
    endfunction

    task automatic model_reset();
        g0 = S0; g1 = S1; g2 = S2;
        macc = '0; mcnt = 0; mv = 0; me = 0;
        exp_q.delete();
    endtask

    // One clock: drive inputs, check DUT against model at negedge, advance model, return at posedge+1.
    task automatic cyc(input bit en, input bit wr, input logic [1:0] sel,
                       input logic [29:0] data, input bit rdy);
        bit ld, step, done, b, c;
        gen_en = en; seed_wr = wr; seed_sel = sel; seed_data = data; out_ready = rdy;
        @(negedge clk);
        chk("out_valid", {63'd0, out_valid}, {63'd0, mv});
        chk("seed_err", {63'd0, seed_err}, {63'd0, me});
        chk("bit_cnt", 64'(bit_cnt), 64'(mcnt));
        chk("r0", 64'(dut.r0), 64'(g0));
        chk("r1", 64'(dut.r1), 64'(g1));
        chk("r2", 64'(dut.r2), 64'(g2));
        if (mv && exp_q.size() > 0) begin
            chk("out_data", 64'(out_data), 64'(exp_q[0]));
            if (rdy) begin
                void'(exp_q.pop_front());
                n_pop++;
            end
        end
        ld = 0; done = 0; me = 0;
        step = en && !wr && !(mv && !rdy);
        if (wr) begin
            case (sel)
                2'd0: if (data[27:0] != '0) begin g0 = {2'b0, data[27:0]}; ld = 1; end else me = 1;
                2'd1: if (data[28:0] != '0) begin g1 = {1'b0, data[28:0]}; ld = 1; end else me = 1;
                2'd2: if (data != '0) begin g2 = data; ld = 1; end else me = 1;
                default: ;
            endcase
        end
        if (ld) begin
            macc = '0; mcnt = 0;
        end
        if (step) begin
            b = g0[0] ^ g1[0];
            c = g2[0];
            g2 = gal(g2, M2);
            if (c) g1 = gal(g1, M1);
            else   g0 = gal(g0, M0);
            macc = {macc[OUT_W-2:0], b};
            mcnt++;
            if (mcnt == OUT_W) begin
                exp_q.push_back(macc);
                mcnt = 0;
                done = 1;
            end
        end
        if (done) mv = 1;
        else if (mv && rdy) mv = 0;
        @(posedge clk);
        #1;
    endtask

    // Asserts reset mid-cycle and checks that it has already taken effect before any clock edge.
    task automatic do_reset();
        rst = 1'b1; gen_en = 1'b0; seed_wr = 1'b0; out_ready = 1'b0;
        #2;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_bit_cnt", 64'(bit_cnt), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_seed_err", {63'd0, seed_err}, 64'd0);
        chk("rst_r0", 64'(dut.r0), 64'(S0));
        chk("rst_r1", 64'(dut.r1), 64'(S1));
        chk("rst_r2", 64'(dut.r2), 64'(S2));
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, n_vec=%0d", n_vec);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        tbl[0] = '{2'd1, 30'h0,        1'b1, S0,          S1,     S2};
        tbl[1] = '{2'd1, 30'h1234,     1'b0, S0,          30'h1234, S2};
        tbl[2] = '{2'd0, 30'h30000000, 1'b1, S0,          30'h1234, S2};
        tbl[3] = '{2'd3, 30'h0,        1'b0, S0,          30'h1234, S2};
        tbl[4] = '{2'd2, 30'h2aaaaaaa, 1'b0, S0,          30'h1234, 30'h2aaaaaaa};
        tbl[5] = '{2'd0, 30'h3fffffff, 1'b0, 30'h0fffffff, 30'h1234, 30'h2aaaaaaa};
        tbl[6] = '{2'd1, 30'h20000000, 1'b1, 30'h0fffffff, 30'h1234, 30'h2aaaaaaa};
        tbl[7] = '{2'd3, 30'h3fffffff, 1'b0, 30'h0fffffff, 30'h1234, 30'h2aaaaaaa};

        #1;
        // Free-running stream: latency of the first word and 1000 words against the model.
        do_reset();
        lat = -1;
        n_pop = 0;
        for (int i = 0; i <= 1000 * OUT_W; i++) begin
            if (lat < 0 && out_valid) lat = i;
            cyc(1, 0, 2'd0, '0, 1);
        end
        chk("first_valid_latency", 64'(lat), 64'(OUT_W));
        chk("t1_word_count", 64'(n_pop), 64'd1000);

        // Back-pressure: hold the first word for 20 cycles, then resume and randomise ready.
        do_reset();
        for (int i = 0; i < OUT_W; i++) cyc(1, 0, 2'd0, '0, 1);
        for (int i = 0; i < 20; i++) cyc(1, 0, 2'd0, '0, 0);
        for (int i = 0; i < 200; i++) cyc(1, 0, 2'd0, '0, 1);
        for (int i = 0; i < 400; i++) cyc(1, 0, 2'd0, '0, 1'($urandom_range(0, 1)));

        // Seed table applied from the reset state.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, tbl[i].sel, tbl[i].data, 1);
            chk("tbl_seed_err", {63'd0, seed_err}, {63'd0, tbl[i].err});
            chk("tbl_r0", 64'(dut.r0), 64'(tbl[i].r0));
            chk("tbl_r1", 64'(dut.r1), 64'(tbl[i].r1));
            chk("tbl_r2", 64'(dut.r2), 64'(tbl[i].r2));
        end
        cyc(0, 0, 2'd0, '0, 1);
        for (int i = 0; i < 5; i++) cyc(1, 0, 2'd0, '0, 1);
        cyc(1, 1, 2'd1, 30'h1234, 1);
        chk("reseed_r1", 64'(dut.r1), 64'h1234);
        chk("reseed_bit_cnt", 64'(bit_cnt), 64'd0);
        for (int i = 0; i < 100 * OUT_W; i++) cyc(1, 0, 2'd0, '0, 1);
        // Reseed while a word is held: the word must survive.
        for (int i = 0; i < 2 * OUT_W && !mv; i++) cyc(1, 0, 2'd0, '0, 0);
        cyc(1, 0, 2'd0, '0, 0);
        cyc(1, 1, 2'd0, 30'h5555, 0);
        chk("held_word_valid", {63'd0, out_valid}, 64'd1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 2'd0, '0, 0);
        for (int i = 0; i < 50 * OUT_W; i++) cyc(1, 0, 2'd0, '0, 1);

        // Async reset five bits into a word, then the stream must restart from the seeds.
        do_reset();
        for (int i = 0; i < OUT_W + 5; i++) cyc(1, 0, 2'd0, '0, 1);
        chk("pre_rst_bit_cnt", 64'(bit_cnt), 64'd5);
        do_reset();
        for (int i = 0; i < 50 * OUT_W; i++) cyc(1, 0, 2'd0, '0, 1);

        // Enable toggling every cycle: same stream at half rate.
        do_reset();
        n_pop = 0;
        for (int i = 0; i < 200 * OUT_W; i++) cyc(i % 2 == 0, 0, 2'd0, '0, 1);
        chk("t5_word_count", 64'(n_pop), 64'd100);

        // All-zero R0 is recovered to its seed on the next edge.
        do_reset();
        cyc(0, 0, 2'd0, '0, 1);
        force dut.r0 = '0;
        #1;
        release dut.r0;
        @(posedge clk);
        #1;
        chk("zero_guard_r0", 64'(dut.r0), 64'(S0));
        chk("zero_guard_no_x", {63'd0, $isunknown(out_data)}, 64'd0);
        for (int i = 0; i < 20 * OUT_W; i++) cyc(1, 0, 2'd0, '0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
